// File: rtl/iot_stream_filter.sv
// rtl/iot_stream_filter.sv - byte-serial IoT datum filter (max/min/avg/range/peak)
//
// Collects BYTES bytes (MSB first) per datum and ROUND data per round, then
// reports one result per round (MAX/MIN/AVG/PEAK) or one result per datum
// (EXTRACT/EXCLUDE range filtering).
//
// Optional feature macro: IOT_PEAK_EN enables PEAK_MAX/PEAK_MIN (fn_sel 110/111).
// Without it those encodings behave like the reserved code 000.
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   in_en   - iot_in carries a byte this cycle
//   iot_in  - datum byte, most significant byte first
//   fn_sel  - function select, sampled on the first byte of each round
//   busy    - result cycle; bytes presented now are dropped
//   valid   - one-cycle pulse qualifying iot_out
//   iot_out - result datum, held while valid is low
module iot_stream_filter #(
    parameter int BYTES = 16,
    parameter int ROUND = 8,
    parameter logic [8*BYTES-1:0] LOW  = {4'h6, {(8*BYTES-4){1'b1}}},
    parameter logic [8*BYTES-1:0] HIGH = {4'hA, {(8*BYTES-4){1'b1}}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_en,
    input  logic [7:0]           iot_in,
    input  logic [2:0]           fn_sel,
    output logic                 busy,
    output logic                 valid,
    output logic [8*BYTES-1:0]   iot_out
);
    localparam int W  = 8 * BYTES;
    localparam int LR = $clog2(ROUND);
    localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int SW = (W > 8) ? W - 8 : 1;

    localparam logic [2:0] FN_MAX     = 3'b001;
    localparam logic [2:0] FN_MIN     = 3'b010;
    localparam logic [2:0] FN_AVG     = 3'b011;
    localparam logic [2:0] FN_EXTRACT = 3'b100;
    localparam logic [2:0] FN_EXCLUDE = 3'b101;
`ifdef IOT_PEAK_EN
    localparam logic [2:0] FN_PMAX    = 3'b110;
    localparam logic [2:0] FN_PMIN    = 3'b111;
`endif

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_valid;
    logic [W-1:0]    r_out;
    logic [BW-1:0]   r_bcnt;
    logic [LR-1:0]   r_dcnt;
    logic [2:0]      r_fn;
    logic [SW-1:0]   r_shift;
    logic [W-1:0]    r_acc;
    logic [W+LR-1:0] r_sum;
`ifdef IOT_PEAK_EN
    logic [W-1:0]    r_peak;
    logic            r_peak_vld;
`endif

    logic            w_acc;
    logic            w_first;
    logic            w_dat_done;
    logic            w_rnd_done;
    logic [2:0]      w_fn;
    logic [W-1:0]    w_datum;
    logic [W-1:0]    w_max;
    logic [W-1:0]    w_min;
    logic [W+LR-1:0] w_sum;
    logic [W-1:0]    w_avg;
    logic            w_round_mode;
    logic            w_sel_min;

    assign w_acc      = in_en && !r_busy;
    // Counters are both zero only between rounds, so this marks a round start.
    assign w_first    = w_acc && (r_bcnt == '0) && (r_dcnt == '0);
    // The round's function comes straight from fn_sel on its first byte.
    assign w_fn       = w_first ? fn_sel : r_fn;
    assign w_dat_done = w_acc && (r_bcnt == BW'(BYTES - 1));
    assign w_rnd_done = w_dat_done && (r_dcnt == LR'(ROUND - 1));
    assign w_datum    = W'({r_shift, iot_in});

    // Strict compares keep the earlier datum on ties.
    assign w_max = ((r_dcnt == '0) || (w_datum > r_acc)) ? w_datum : r_acc;
    assign w_min = ((r_dcnt == '0) || (w_datum < r_acc)) ? w_datum : r_acc;
    assign w_sum = ((r_dcnt == '0) ? '0 : r_sum) + {{LR{1'b0}}, w_datum};
    assign w_avg = w_sum[W+LR-1:LR];

`ifdef IOT_PEAK_EN
    assign w_round_mode = (w_fn == FN_MAX) || (w_fn == FN_MIN) || (w_fn == FN_AVG) ||
                          (w_fn == FN_PMAX) || (w_fn == FN_PMIN);
    assign w_sel_min    = (w_fn == FN_MIN) || (w_fn == FN_PMIN);
`else
    assign w_round_mode = (w_fn == FN_MAX) || (w_fn == FN_MIN) || (w_fn == FN_AVG);
    assign w_sel_min    = (w_fn == FN_MIN);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_out      <= '0;
            r_bcnt     <= '0;
            r_dcnt     <= '0;
            r_fn       <= 3'b000;
            r_shift    <= '0;
            r_acc      <= '0;
            r_sum      <= '0;
`ifdef IOT_PEAK_EN
            r_peak     <= '0;
            r_peak_vld <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;

            case (r_state)
                IDLE: if (w_first) r_state <= ACC;
                ACC: if (w_rnd_done && w_round_mode) begin
                    r_state <= OUT;
                    r_busy  <= 1'b1;
                end
                OUT: begin
                    r_state <= ACC;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase

            if (w_acc) begin
                r_shift <= w_datum[SW-1:0];
                r_bcnt  <= w_dat_done ? '0 : r_bcnt + 1'b1;
                if (w_first) begin
                    r_fn <= fn_sel;
`ifdef IOT_PEAK_EN
                    if (fn_sel != r_fn) begin
                        r_peak_vld <= 1'b0;
                        r_peak     <= '0;
                    end
`endif
                end
                if (w_dat_done) begin
                    r_dcnt <= w_rnd_done ? '0 : r_dcnt + 1'b1;
                    r_sum  <= w_sum;
                    r_acc  <= w_sel_min ? w_min : w_max;
                    case (w_fn)
                        FN_MAX: if (w_rnd_done) begin
                            r_valid <= 1'b1;
                            r_out   <= w_max;
                        end
                        FN_MIN: if (w_rnd_done) begin
                            r_valid <= 1'b1;
                            r_out   <= w_min;
                        end
                        FN_AVG: if (w_rnd_done) begin
                            r_valid <= 1'b1;
                            r_out   <= w_avg;
                        end
                        FN_EXTRACT: if ((w_datum > LOW) && (w_datum < HIGH)) begin
                            r_valid <= 1'b1;
                            r_out   <= w_datum;
                        end
                        FN_EXCLUDE: if ((w_datum < LOW) || (w_datum > HIGH)) begin
                            r_valid <= 1'b1;
                            r_out   <= w_datum;
                        end
`ifdef IOT_PEAK_EN
                        FN_PMAX: if (w_rnd_done && (!r_peak_vld || (w_max > r_peak))) begin
                            r_valid    <= 1'b1;
                            r_out      <= w_max;
                            r_peak     <= w_max;
                            r_peak_vld <= 1'b1;
                        end
                        FN_PMIN: if (w_rnd_done && (!r_peak_vld || (w_min < r_peak))) begin
                            r_valid    <= 1'b1;
                            r_out      <= w_min;
                            r_peak     <= w_min;
                            r_peak_vld <= 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    assign busy    = r_busy;
    assign valid   = r_valid;
    assign iot_out = r_out;

endmodule

// File: doc/iot_stream_filter.md
IOT_STREAM_FILTER -- requirements
Module: iot_stream_filter

Interface
REQ-001 The block SHALL have parameter BYTES, default 16, meaning bytes per datum; datum width W = 8*BYTES.
REQ-002 The block SHALL have parameter ROUND, default 8, meaning data per round; it SHALL be a power of two, range 2..64.
REQ-003 The block SHALL have parameter LOW, default 0x6FFF...FF (W bits), meaning the lower bound for EXTRACT/EXCLUDE.
REQ-004 The block SHALL have parameter HIGH, default 0xAFFF...FF (W bits), meaning the upper bound for EXTRACT/EXCLUDE.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_en, input, 1 bit: iot_in carries a valid byte this cycle.
REQ-008 The block SHALL have port iot_in, input, 8 bits: datum byte, most significant byte first.
REQ-009 The block SHALL have port fn_sel, input, 3 bits, with encodings:
- 001 MAX
- 010 MIN
- 011 AVG
- 100 EXTRACT
- 101 EXCLUDE
- 110 PEAK_MAX
- 111 PEAK_MIN
- 000 reserved
REQ-010 The block SHALL have port busy, output, 1 bit: the block cannot accept a byte this cycle.
REQ-011 The block SHALL have port valid, output, 1 bit: a one-cycle pulse marking iot_out valid.
REQ-012 The block SHALL have port iot_out, output, W bits: the result datum.

Function
REQ-013 A byte SHALL be accepted when in_en=1 and busy=0; an in_en=0 cycle SHALL pause the byte counter without discarding partial data.
REQ-014 A datum SHALL complete on its BYTES-th accepted byte; a round SHALL complete on its ROUND-th datum.
REQ-015 fn_sel SHALL be sampled on the first accepted byte of each round and held for that round; changes mid-round SHALL be ignored.
REQ-016 The FSM SHALL use three states with these transitions:
- IDLE -> ACC on first accepted byte
- ACC -> OUT on round completion in MAX/MIN/AVG/PEAK modes
- OUT -> ACC after exactly one cycle
REQ-017 busy SHALL be 1 only in OUT; a byte presented with in_en=1 in OUT SHALL be ignored.
REQ-018 MAX/MIN: in OUT, valid=1 and iot_out SHALL equal the unsigned max/min of the round's data; ties SHALL keep the earlier datum.
REQ-019 AVG: sum SHALL be held in W+log2(ROUND) bits without overflow; output SHALL be floor(sum/ROUND), truncated by shift.
REQ-020 EXTRACT: in the cycle after a datum completes, valid=1 with that datum iff LOW < datum < HIGH (strict, unsigned); no OUT state or busy is used.
REQ-021 EXCLUDE: same timing as EXTRACT; valid=1 iff datum < LOW or datum > HIGH.
REQ-022 PEAK_MAX/PEAK_MIN: at round completion, the round max/min SHALL be compared with the stored peak.
- The first round after reset SHALL always output and store its value.
- Later rounds SHALL output and update the peak only if strictly greater (PEAK_MAX) or strictly less (PEAK_MIN).
- Otherwise OUT SHALL occur with busy=1 and valid=0.
REQ-023 The peak register SHALL be cleared to "empty" whenever the sampled fn_sel differs from the previous round's fn_sel.
REQ-024 fn_sel 000: bytes SHALL be consumed and counted, and valid SHALL never assert.
REQ-025 iot_out SHALL hold its last value when valid=0.

Reset
REQ-026 With rst_n=0, the block SHALL immediately apply busy=0, valid=0, iot_out=0, FSM=IDLE, byte/datum counters=0, accumulators=0, and peak=empty.
REQ-027 Reset mid-round SHALL discard all partial data; the first byte after release SHALL start a new round.

Configuration
REQ-028 With macro IOT_PEAK_EN defined, PEAK_MAX/PEAK_MIN SHALL behave per REQ-022/023.
REQ-029 Without IOT_PEAK_EN, the peak register and its comparators SHALL be absent, and fn_sel 110/111 SHALL behave as reserved (REQ-024).

Verification (BYTES=2, ROUND=4, LOW=0x1000, HIGH=0x2000)
REQ-030 MAX: data 0x0005, 0x0300, 0x0007, 0x0001 -> one cycle after the 8th byte: valid=1, busy=1, iot_out=0x0300.
REQ-031 AVG: data 0x0001, 0x0002, 0x0003, 0x0004 -> iot_out=0x0002 (10/4 floored); 0xFFFF x4 -> 0xFFFF (no overflow).
REQ-032 EXTRACT: data 0x1000, 0x1001, 0x2000, 0x1FFF -> valid pulses only for 0x1001 and 0x1FFF, each one cycle after its last byte.
REQ-033 PEAK_MAX (IOT_PEAK_EN): round maxima 0x0050, 0x0040, 0x0060 -> outputs 0x0050, none (busy=1, valid=0), 0x0060.
REQ-034 in_en gap mid-datum of 3 cycles, plus a byte presented during OUT -> result unchanged; the OUT byte is not counted.
REQ-035 rst_n low after 5 bytes of a MIN round -> outputs zero; the next full round 0x0009, 0x0004, 0x0008, 0x0006 -> iot_out=0x0004.
